// File: rtl/ped_request_if.sv
// rtl/ped_request_if.sv - button/served inputs and request outputs of the pedestrian front end
interface ped_request_if;
   logic       btn;
   logic       served;
   logic       Ped;
   logic       wait_lamp;
   logic       btn_clean;
   logic [7:0] press_cnt;

   modport master (
      output btn,
      output served,
      input  Ped,
      input  wait_lamp,
      input  btn_clean,
      input  press_cnt
   );

   modport slave (
      input  btn,
      input  served,
      output Ped,
      output wait_lamp,
      output btn_clean,
      output press_cnt
   );
endinterface

// File: rtl/ped_request.sv
// rtl/ped_request.sv - crosswalk button synchroniser, debouncer and request latch
// One request per clean press; held until the controller serves it, re-armed after service ends.
module ped_request #(
   parameter int DEB_CYCLES = 500000,
   parameter int CNT_W      = 20
) (
   input  logic          clock,
   input  logic          reset,
   ped_request_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, PENDING, SERVING} state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic             clean;
   logic             prev;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       press_cnt;
   logic             press;
   logic             count_en;
   state_t           state;
   state_t           state_nxt;

   // Any sample matching the current clean level restarts the stability count.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         clean <= 1'b0;
         prev  <= 1'b0;
      end else begin
         s1   <= bus.btn;
         s2   <= s1;
         prev <= clean;
         if (s2 == clean) begin
            cnt <= '0;
         end else if (cnt == DEB_LAST) begin
            clean <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign press = clean & ~prev;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         press_cnt <= 8'd0;
      end else begin
         state     <= state_nxt;
         press_cnt <= press_cnt + {7'd0, count_en};
      end
   end

   always_comb begin
      state_nxt = state;
      count_en  = 1'b0;
      case (state)
         IDLE: begin
            if (press) begin
               state_nxt = PENDING;
               count_en  = 1'b1;
            end
         end
         PENDING: begin
            if (bus.served) state_nxt = SERVING;
         end
         SERVING: begin
            if (!bus.served) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.Ped       = (state == PENDING);
   assign bus.wait_lamp = (state == PENDING);
   assign bus.btn_clean = clean;
   assign bus.press_cnt = press_cnt;

endmodule

// File: tb/tb_ped_request.sv
// tb/tb_ped_request.sv - vector table, hand sequences and randomized model check for ped_request
module tb_ped_request;

   localparam int DEB = 4;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   ped_request_if bus ();

   ped_request #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Reference: clean level flips once the last DEB synchronised samples all disagree with it.
   bit       hist[$];
   bit       m_clean;
   bit       m_prev;
   int       m_phase;   // 0 waiting for press, 1 request outstanding, 2 being served
   bit [7:0] m_cnt;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit b, input bit s);
      bit press;
      bit all_diff;
      bit v;
      int idx;
      if (r) begin
         hist.delete();
         m_clean = 1'b0;
         m_prev  = 1'b0;
         m_phase = 0;
         m_cnt   = 8'd0;
      end else begin
         press    = m_clean && !m_prev;
         all_diff = 1'b1;
         for (int j = 0; j < DEB; j++) begin
            idx = hist.size() - 2 - j;
            v   = (idx >= 0) ? hist[idx] : 1'b0;
            if (v == m_clean) all_diff = 1'b0;
         end
         m_prev = m_clean;
         if (all_diff) m_clean = !m_clean;
         case (m_phase)
            0: if (press) begin m_phase = 1; m_cnt = m_cnt + 8'd1; end
            1: if (s) m_phase = 2;
            default: if (!s) m_phase = 0;
         endcase
         hist.push_back(b);
         if (hist.size() > DEB + 4) void'(hist.pop_front());
      end
   endtask

   task automatic step(input bit r, input bit b, input bit s);
      reset      = r;
      bus.btn    = b;
      bus.served = s;
      @(posedge clock);
      model_edge(r, b, s);
      #1;
      check("model_ped",   int'(bus.Ped),       int'(m_phase == 1));
      check("model_wait",  int'(bus.wait_lamp), int'(m_phase == 1));
      check("model_clean", int'(bus.btn_clean), int'(m_clean));
      check("model_cnt",   int'(bus.press_cnt), int'(m_cnt));
   endtask

   typedef struct {
      bit rst;
      bit b;
      bit s;
      int n;
      bit e_ped;
      bit e_clean;
      int e_cnt;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int hold_b;
      int hold_s;
      bit rb;
      bit rs;
      bit rr;

      reset      = 1'b1;
      bus.btn    = 1'b0;
      bus.served = 1'b0;

      step(1, 0, 0);
      step(1, 0, 0);
      check("rst_ped",   int'(bus.Ped),       0);
      check("rst_wait",  int'(bus.wait_lamp), 0);
      check("rst_clean", int'(bus.btn_clean), 0);
      check("rst_cnt",   int'(bus.press_cnt), 0);

      //            rst b  s  n  ped cln cnt
      tbl.push_back('{0, 0, 0, 3, 0, 0, 0});
      for (int i = 0; i < 5; i++) begin
         tbl.push_back('{0, 1, 0, 3, 0, 0, 0});
         tbl.push_back('{0, 0, 0, 2, 0, 0, 0});
      end
      tbl.push_back('{0, 0, 0, 6, 0, 0, 0});
      // clean press: clean at 6th edge of held-high, request at 7th
      tbl.push_back('{0, 1, 0, 5, 0, 0, 0});
      tbl.push_back('{0, 1, 0, 1, 0, 1, 0});
      tbl.push_back('{0, 1, 0, 1, 1, 1, 1});
      tbl.push_back('{0, 1, 0, 5, 1, 1, 1});
      // release and re-press while pending
      tbl.push_back('{0, 0, 0, 6, 1, 0, 1});
      tbl.push_back('{0, 1, 0, 7, 1, 1, 1});
      tbl.push_back('{0, 0, 0, 7, 1, 0, 1});
      // served handshake, press during service ignored
      tbl.push_back('{0, 0, 1, 1, 0, 0, 1});
      tbl.push_back('{0, 1, 1, 7, 0, 1, 1});
      tbl.push_back('{0, 0, 1, 7, 0, 0, 1});
      tbl.push_back('{0, 0, 0, 1, 0, 0, 1});
      tbl.push_back('{0, 1, 0, 7, 1, 1, 2});
      // press in idle with served already high: pending one edge, then serving
      tbl.push_back('{0, 0, 0, 7, 1, 0, 2});
      tbl.push_back('{0, 0, 1, 1, 0, 0, 2});
      tbl.push_back('{0, 0, 0, 1, 0, 0, 2});
      tbl.push_back('{0, 1, 1, 7, 1, 1, 3});
      tbl.push_back('{0, 1, 1, 1, 0, 1, 3});
      tbl.push_back('{0, 1, 0, 1, 0, 1, 3});
      // reset while pending with the button held
      tbl.push_back('{0, 0, 0, 7, 0, 0, 3});
      tbl.push_back('{0, 1, 0, 7, 1, 1, 4});
      tbl.push_back('{1, 1, 0, 1, 0, 0, 0});
      tbl.push_back('{0, 1, 0, 6, 0, 1, 0});
      tbl.push_back('{0, 1, 0, 1, 1, 1, 1});

      for (int k = 0; k < tbl.size(); k++) begin
         for (int c = 0; c < tbl[k].n; c++) step(tbl[k].rst, tbl[k].b, tbl[k].s);
         check($sformatf("tbl_ped[%0d]", k),   int'(bus.Ped),       int'(tbl[k].e_ped));
         check($sformatf("tbl_wait[%0d]", k),  int'(bus.wait_lamp), int'(tbl[k].e_ped));
         check($sformatf("tbl_clean[%0d]", k), int'(bus.btn_clean), int'(tbl[k].e_clean));
         check($sformatf("tbl_cnt[%0d]", k),   int'(bus.press_cnt), tbl[k].e_cnt);
      end

      // counter wrap over 256 full request/service rounds
      step(1, 0, 0);
      for (int i = 0; i < 256; i++) begin
         for (int c = 0; c < 7; c++) step(0, 1, 0);
         check("wrap_ped", int'(bus.Ped), 1);
         if (i == 254) check("wrap_255", int'(bus.press_cnt), 255);
         if (i == 255) check("wrap_0",   int'(bus.press_cnt), 0);
         for (int c = 0; c < 7; c++) step(0, 0, 1);
         step(0, 0, 0);
      end

      hold_b = 0;
      hold_s = 0;
      rb     = 1'b0;
      rs     = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (hold_b == 0) begin
            rb     = 1'($urandom_range(0, 1));
            hold_b = $urandom_range(1, 9);
         end
         if (hold_s == 0) begin
            rs     = 1'($urandom_range(0, 1));
            hold_s = $urandom_range(1, 12);
         end
         rr = ($urandom_range(0, 199) == 0);
         step(rr, rb, rs);
         hold_b--;
         hold_s--;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
